// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, receiver state encoding and baud divisor
//               helper for the UART receive path.
// Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Oversampling factor of the receiver
    localparam int OVERSAMPLE = 16;

    // Receiver states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Rounded sys_clk cycles per oversampling tick
    function automatic int calc_div(input longint clk_freq, input longint baud);
        longint l_den;
        l_den = baud * longint'(OVERSAMPLE);
        return int'((clk_freq + (l_den / 2)) / l_den);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock first-word-fall-through FIFO. Head entry is
//               visible on o_data whenever o_empty is low; a pop advances it.
//               A push while full is accepted only if a pop happens in the
//               same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [c_addr_w-1:0] r_wr_ptr;
    logic [c_addr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == c_full_cnt);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~w_empty;
    // A full FIFO still takes a write when the head leaves in the same cycle
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Head is forced to zero while empty so stale storage never shows
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 16x oversampling UART receiver with majority-vote sampling,
//               configurable data width / parity / stop bits, feeding a FWFT
//               receive FIFO that carries per-character error flags.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_resetn,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_perr,
    output logic                          m_ferr,
    output logic                          m_break,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int c_div    = calc_div(CLK_FREQ, BAUD);
    localparam int c_div_w  = (c_div > 1) ? $clog2(c_div) : 1;
    localparam int c_idx_w  = $clog2(DATA_BITS);
    localparam int c_fifo_w = DATA_BITS + 3;

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle   = ST_IDLE;
    localparam logic [2:0] c_st_start  = ST_START;
    localparam logic [2:0] c_st_data   = ST_DATA;
    localparam logic [2:0] c_st_parity = ST_PARITY;
    localparam logic [2:0] c_st_stop   = ST_STOP;

    // Synchroniser and edge detect
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;
    logic w_fall;

    // Timing
    logic [c_div_w-1:0] r_div_cnt;
    logic [3:0]         r_tick_cnt;
    logic               w_tick;
    logic               w_decide;
    logic               w_bit_end;

    // Sampling and frame assembly
    logic                 r_s7;
    logic                 r_s8;
    logic                 w_bit;
    logic [2:0]           r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 w_last_stop;
    logic                 w_par_sum;
    logic                 w_perr_bit;
    logic                 w_ferr_final;
    logic                 w_break;

    // FIFO side
    logic                r_push;
    logic [c_fifo_w-1:0] r_push_data;
    logic [c_fifo_w-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_drop;
    logic                r_overflow;

    // Two-flop synchroniser plus one history flop for start-edge detection
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall = r_rx_prev & ~r_rx_sync;

    // Tick divider held at zero while idle so bit timing starts at the edge
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_div_cnt <= '0;
        end else if (r_state == c_st_idle) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_div_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign w_tick    = (r_state != c_st_idle) && (r_div_cnt == c_div_last);
    assign w_decide  = w_tick && (r_tick_cnt == 4'd9);
    assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);

    // Majority of the samples at ticks 7, 8 and the live value at tick 9
    assign w_bit = (r_s7 & r_s8) | (r_s7 & r_rx_sync) | (r_s8 & r_rx_sync);

    assign w_par_sum    = (^r_shift) ^ w_bit;
    assign w_perr_bit   = (PARITY == PAR_ODD) ? ~w_par_sum : w_par_sum;
    assign w_ferr_final = r_ferr | ~w_bit;
    assign w_break      = (r_shift == '0) && w_ferr_final;
    assign w_last_stop  = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;

    // Receive state machine; the frame is pushed at the final stop decision
    // and the receiver returns to idle mid stop bit to resync early
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state     <= c_st_idle;
            r_tick_cnt  <= '0;
            r_s7        <= 1'b1;
            r_s8        <= 1'b1;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_perr      <= 1'b0;
            r_ferr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_state == c_st_idle) begin
                if (w_fall) begin
                    r_state    <= c_st_start;
                    r_tick_cnt <= '0;
                    r_bit_idx  <= '0;
                    r_stop_idx <= 1'b0;
                    r_perr     <= 1'b0;
                    r_ferr     <= 1'b0;
                end
            end else if (w_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
                if (r_tick_cnt == 4'd7) begin
                    r_s7 <= r_rx_sync;
                end
                if (r_tick_cnt == 4'd8) begin
                    r_s8 <= r_rx_sync;
                end
                case (r_state)
                    c_st_start: begin
                        if (w_decide && w_bit) begin
                            r_state <= c_st_idle;
                        end else if (w_bit_end) begin
                            r_state <= c_st_data;
                        end
                    end
                    c_st_data: begin
                        if (w_decide) begin
                            r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                        end
                        if (w_bit_end) begin
                            if (r_bit_idx == c_last_idx) begin
                                r_bit_idx <= '0;
                                r_state   <= (PARITY != PAR_NONE) ? c_st_parity : c_st_stop;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end
                    end
                    c_st_parity: begin
                        if (w_decide) begin
                            r_perr <= w_perr_bit;
                        end
                        if (w_bit_end) begin
                            r_state <= c_st_stop;
                        end
                    end
                    c_st_stop: begin
                        if (w_decide) begin
                            if (w_last_stop) begin
                                r_push      <= 1'b1;
                                r_push_data <= {w_break, w_ferr_final, r_perr, r_shift};
                                r_state     <= c_st_idle;
                            end else begin
                                r_ferr <= w_ferr_final;
                            end
                        end else if (w_bit_end) begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (c_fifo_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_resetn),
        .i_push  (r_push),
        .i_data  (r_push_data),
        .i_pop   (m_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    // A push is lost only when full and the head is not leaving this cycle
    assign w_drop = r_push & w_full & ~(m_ready & ~w_empty);

    // Sticky overflow flag; a new drop outranks a clear request
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign m_data   = w_head[DATA_BITS-1:0];
    assign m_perr   = w_head[DATA_BITS];
    assign m_ferr   = w_head[DATA_BITS+1];
    assign m_break  = w_head[DATA_BITS+2];
    assign m_valid  = ~w_empty;
    assign overflow = r_overflow;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Self-checking bench for uart_rx_fifo. Three receivers:
//               a = 8N1 at 50 MHz / 115200, b = 8E1 (fast divisor),
//               c = 7O2 with a 4-deep FIFO (fast divisor).
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_fifo;
    import uart_pkg::*;

    localparam int c_per_a    = 432;   // 27 clocks/tick * 16
    localparam int c_per_fast = 64;    // 4 clocks/tick * 16

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       sys_resetn;
    logic [2:0] rx_v;
    logic [2:0] rdy_v;
    logic [2:0] clr_v;

    logic [7:0] m_data_a;
    logic [7:0] m_data_b;
    logic [6:0] m_data_c;
    logic [2:0] perr_v, ferr_v, brk_v, vld_v, ovf_v;
    logic [4:0] cnt_a, cnt_b;
    logic [2:0] cnt_c;

    logic [11:0] head [3];
    assign head[0] = {brk_v[0], ferr_v[0], perr_v[0], 1'b0, m_data_a};
    assign head[1] = {brk_v[1], ferr_v[1], perr_v[1], 1'b0, m_data_b};
    assign head[2] = {brk_v[2], ferr_v[2], perr_v[2], 2'b00, m_data_c};

    uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(115200), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
        .sys_clk(sys_clk), .sys_resetn(sys_resetn), .rx(rx_v[0]),
        .m_data(m_data_a), .m_perr(perr_v[0]), .m_ferr(ferr_v[0]),
        .m_break(brk_v[0]), .m_valid(vld_v[0]), .m_ready(rdy_v[0]),
        .count(cnt_a), .overflow(ovf_v[0]), .clr_ovf(clr_v[0]));

    uart_rx_fifo #(.CLK_FREQ(4_000_000), .BAUD(62_500), .DATA_BITS(8),
                   .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_b (
        .sys_clk(sys_clk), .sys_resetn(sys_resetn), .rx(rx_v[1]),
        .m_data(m_data_b), .m_perr(perr_v[1]), .m_ferr(ferr_v[1]),
        .m_break(brk_v[1]), .m_valid(vld_v[1]), .m_ready(rdy_v[1]),
        .count(cnt_b), .overflow(ovf_v[1]), .clr_ovf(clr_v[1]));

    uart_rx_fifo #(.CLK_FREQ(4_000_000), .BAUD(62_500), .DATA_BITS(7),
                   .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
        .sys_clk(sys_clk), .sys_resetn(sys_resetn), .rx(rx_v[2]),
        .m_data(m_data_c), .m_perr(perr_v[2]), .m_ferr(ferr_v[2]),
        .m_break(brk_v[2]), .m_valid(vld_v[2]), .m_ready(rdy_v[2]),
        .count(cnt_c), .overflow(ovf_v[2]), .clr_ovf(clr_v[2]));

    int n_checks = 0;
    int n_fail   = 0;

    // Entries: {instance[1:0], break, ferr, perr, data[8:0]}
    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];

    // Record every accepted beat, sampled 1 ns after the falling edge
    always @(negedge sys_clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (vld_v[i] && rdy_v[i]) begin
                got_q.push_back({2'(i), head[i]});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input int inst, input logic v, input int period);
        rx_v[inst] = v;
        repeat (period) @(negedge sys_clk);
    endtask

    // Reference model: computes the expected FIFO entry from frame rules,
    // then serialises the frame onto the instance's rx line.
    task automatic send_frame(input int inst, input int data, input int nbits,
                              input int par_mode, input int nstop, input bit par_flip,
                              input int stop_zero, input int period, input bit keep);
        logic [8:0] d;
        logic pbit, sum, perr, ferr, brk;
        d = 9'(data & ((1 << nbits) - 1));
        pbit = (par_mode == PAR_ODD) ? ~(^d) : (^d);
        if (par_flip) pbit = ~pbit;
        sum = (^d) ^ pbit;
        case (par_mode)
            PAR_ODD:  perr = (sum != 1'b1);
            PAR_EVEN: perr = (sum != 1'b0);
            default:  perr = 1'b0;
        endcase
        ferr = 1'b0;
        for (int s = 0; s < nstop; s++) begin
            if (((stop_zero >> s) & 1) != 0) ferr = 1'b1;
        end
        brk = (d == 9'd0) && ferr;
        if (keep) exp_q.push_back({2'(inst), brk, ferr, perr, d});
        drive_bit(inst, 1'b0, period);
        for (int i = 0; i < nbits; i++) drive_bit(inst, d[i], period);
        if (par_mode != PAR_NONE) drive_bit(inst, pbit, period);
        for (int s = 0; s < nstop; s++) drive_bit(inst, (((stop_zero >> s) & 1) == 0), period);
        drive_bit(inst, 1'b1, period);
    endtask

    task automatic drain(input int inst, input string tag);
        rdy_v[inst] = 1'b1;
        for (int k = 0; k < 200 && vld_v[inst]; k++) @(negedge sys_clk);
        check({tag, "_drained"}, 32'(vld_v[inst]), 32'd0);
        rdy_v[inst] = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        logic [13:0] e, g;
        check({tag, "_nbeats"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, "_beat"}, 32'(g), 32'(e));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_valid%0d", tag, i), 32'(vld_v[i]), 32'd0);
            check($sformatf("%s_head%0d", tag, i), 32'(head[i]), 32'd0);
            check($sformatf("%s_ovf%0d", tag, i), 32'(ovf_v[i]), 32'd0);
        end
        check({tag, "_cnt_a"}, 32'(cnt_a), 32'd0);
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'd0);
        check({tag, "_cnt_c"}, 32'(cnt_c), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rand;
        int sz;
        sys_resetn = 1'b0;
        rx_v  = 3'b111;
        rdy_v = 3'b000;
        clr_v = 3'b000;
        repeat (3) @(negedge sys_clk);
        check_reset("in_reset");
        sys_resetn = 1'b1;
        repeat (4) @(negedge sys_clk);
        check_reset("after_reset");

        // 8N1 0x55 with consumer always ready
        rdy_v[0] = 1'b1;
        send_frame(0, 8'h55, 8, PAR_NONE, 1, 1'b0, 0, c_per_a, 1'b1);
        check("a_count_0x55", 32'(cnt_a), 32'd0);
        compare_all("a_0x55");

        // Start-bit glitch shorter than half a bit
        rx_v[0] = 1'b0;
        repeat (40) @(negedge sys_clk);
        rx_v[0] = 1'b1;
        repeat (2 * c_per_a) @(negedge sys_clk);
        check("glitch_count", 32'(cnt_a), 32'd0);
        check("glitch_valid", 32'(vld_v[0]), 32'd0);
        send_frame(0, 8'hC3, 8, PAR_NONE, 1, 1'b0, 0, c_per_a, 1'b1);
        compare_all("a_after_glitch");
        rdy_v[0] = 1'b0;

        // 8E1: wrong then correct parity
        rdy_v[1] = 1'b1;
        send_frame(1, 8'hA3, 8, PAR_EVEN, 1, 1'b1, 0, c_per_fast, 1'b1);
        send_frame(1, 8'hA3, 8, PAR_EVEN, 1, 1'b0, 0, c_per_fast, 1'b1);
        rdy_v[1] = 1'b0;
        compare_all("b_parity");

        // 7O2: second stop bit low, then an all-zero line (break)
        rdy_v[2] = 1'b1;
        send_frame(2, 8'h41, 7, PAR_ODD, 2, 1'b0, 2, c_per_fast, 1'b1);
        send_frame(2, 0, 7, PAR_ODD, 2, 1'b1, 3, c_per_fast, 1'b1);
        rdy_v[2] = 1'b0;
        compare_all("c_ferr_break");

        // Random frames on 8E1, buffered then drained
        n_rand = 10;
        for (int i = 0; i < n_rand; i++) begin
            send_frame(1, int'($urandom_range(0, 255)), 8, PAR_EVEN, 1,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0) ? 1 : 0,
                       c_per_fast, 1'b1);
        end
        check("b_rand_count", 32'(cnt_b), 32'(n_rand));
        drain(1, "b_rand");
        compare_all("b_rand");

        // Random frames on 7O2 filling its FIFO exactly
        for (int i = 0; i < 4; i++) begin
            sz = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(2, int'($urandom_range(0, 127)), 7, PAR_ODD, 2,
                       ($urandom_range(0, 3) == 0), sz, c_per_fast, 1'b1);
        end
        check("c_rand_count_full", 32'(cnt_c), 32'd4);
        check("c_rand_no_ovf", 32'(ovf_v[2]), 32'd0);
        drain(2, "c_rand");
        compare_all("c_rand");

        // Overflow: 17 characters into a 16-deep FIFO, the last is lost
        for (int i = 0; i < 17; i++) begin
            send_frame(1, i, 8, PAR_EVEN, 1, 1'b0, 0, c_per_fast, (i < 16));
        end
        check("ovf_count", 32'(cnt_b), 32'd16);
        check("ovf_flag", 32'(ovf_v[1]), 32'd1);
        drain(1, "ovf");
        compare_all("ovf_order");
        check("ovf_sticky", 32'(ovf_v[1]), 32'd1);
        clr_v[1] = 1'b1;
        @(negedge sys_clk);
        clr_v[1] = 1'b0;
        check("ovf_cleared", 32'(ovf_v[1]), 32'd0);

        // Reset in the middle of a data bit with one character buffered
        send_frame(1, 8'h5A, 8, PAR_EVEN, 1, 1'b0, 0, c_per_fast, 1'b0);
        check("pre_reset_count", 32'(cnt_b), 32'd1);
        drive_bit(1, 1'b0, c_per_fast);
        drive_bit(1, 1'b0, c_per_fast);
        drive_bit(1, 1'b1, c_per_fast / 2);
        sys_resetn = 1'b0;
        #1;
        check("midreset_valid", 32'(vld_v[1]), 32'd0);
        check("midreset_count", 32'(cnt_b), 32'd0);
        check("midreset_head", 32'(head[1]), 32'd0);
        @(negedge sys_clk);
        rx_v[1] = 1'b1;
        repeat (2) @(negedge sys_clk);
        sys_resetn = 1'b1;
        repeat (2 * c_per_fast) @(negedge sys_clk);
        check("postreset_count", 32'(cnt_b), 32'd0);
        send_frame(1, 8'h3C, 8, PAR_EVEN, 1, 1'b0, 0, c_per_fast, 1'b1);
        drain(1, "postreset");
        compare_all("postreset_0x3c");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
